// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales the oscillator sample by an attack/decay/sustain/release level.
// Latency: 1 clk from sample_in/env_level to sample_out; gate acts 2 clks after it changes.
// Backpressure: none; streams one sample per clk. ADSR_EXP_RELEASE_EN selects exponential release.
module adsr_envelope #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned ENV_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic [ENV_W-1:0] attack_step,
  input  logic [ENV_W-1:0] decay_step,
  input  logic [ENV_W-1:0] sustain_level,
  input  logic [ENV_W-1:0] release_step,
  input  logic [15:0]      sample_in,
  output logic [15:0]      sample_out,
  output logic [ENV_W-1:0] env_level,
  output logic [2:0]       env_state,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [15:0]      TICK_MAX  = 16'(TICK_DIV - 1);
  localparam logic [ENV_W-1:0] LEVEL_MAX = '1;

  state_t           state_q, state_d;
  logic [ENV_W-1:0] level_q, level_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic [15:0]      sample_out_q, sample_out_d;
  logic             tick;

  logic [ENV_W:0]   attack_sum;
  logic [ENV_W:0]   decay_diff;
  logic [ENV_W-1:0] rel_dec;
  logic             rel_instant;
  logic signed [32:0] prod;

  // Free-running prescaler; gate activity never restarts it.
  always_comb begin
    tick  = (cnt_q == TICK_MAX);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

`ifdef ADSR_EXP_RELEASE_EN
  logic [ENV_W-1:0] rel_shr4;
  logic [ENV_W-1:0] rel_shr8;
  logic [ENV_W-1:0] rel_max;
  always_comb begin
    rel_shr4    = level_q >> 4;
    rel_shr8    = release_step >> 8;
    rel_max     = (rel_shr4 > rel_shr8) ? rel_shr4 : rel_shr8;
    rel_dec     = (rel_max == '0) ? {{(ENV_W-1){1'b0}}, 1'b1} : rel_max;
    rel_instant = 1'b0;
  end
`else
  always_comb begin
    rel_dec     = release_step;
    rel_instant = (release_step == '0);
  end
`endif

  always_comb begin
    attack_sum = {1'b0, level_q} + {1'b0, attack_step};
    decay_diff = {1'b0, level_q} - {1'b0, decay_step};
  end

  // Gate edges are seen as gate_q disagreeing with the current phase, so a
  // gate change always wins over a coincident tick and leaves the level alone.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    gate_d  = gate;
    case (state_q)
      S_IDLE: begin
        level_d = '0;
        if (gate_q) begin
          state_d = S_ATTACK;
        end
      end
      S_ATTACK: begin
        if (!gate_q) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if (attack_step == '0 || attack_sum[ENV_W] || attack_sum[ENV_W-1:0] == LEVEL_MAX) begin
            level_d = LEVEL_MAX;
            state_d = S_DECAY;
          end else begin
            level_d = attack_sum[ENV_W-1:0];
          end
        end
      end
      S_DECAY: begin
        if (!gate_q) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          // Also covers sustain_level at or above the entry level.
          if (decay_step == '0 || decay_diff[ENV_W] || decay_diff[ENV_W-1:0] <= sustain_level) begin
            level_d = sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            level_d = decay_diff[ENV_W-1:0];
          end
        end
      end
      S_SUSTAIN: begin
        if (!gate_q) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          level_d = sustain_level;
        end
      end
      S_RELEASE: begin
        if (gate_q) begin
          state_d = S_ATTACK;
        end else if (tick) begin
          if (rel_instant || level_q <= rel_dec) begin
            level_d = '0;
            state_d = S_IDLE;
          end else begin
            level_d = level_q - rel_dec;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Signed sample times unsigned level; keeping the top half is an arithmetic floor.
  always_comb begin
    prod         = $signed({{17{sample_in[15]}}, sample_in}) * $signed({17'b0, level_q});
    sample_out_d = 16'(prod >>> 16);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      level_q      <= '0;
      cnt_q        <= '0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
      sample_out_q <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      gate_q       <= gate_d;
      busy_q       <= busy_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign env_level  = level_q;
  assign env_state  = state_q;
  assign busy       = busy_q;

endmodule
